// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: first-word-fall-through sample buffer feeding a multi-cycle FIR
//
// Ports:
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_en              global enable; low holds all state except the overflow clear
//   iv_din            sample from the free-running source
//   i_din_valid       one-cycle write strobe from the source
//   ov_dout           registered head sample, stable until consumed
//   o_dout_valid      head sample valid
//   i_ready           consume strobe from the FIR
//   ov_count          fill level
//   o_empty, o_full   fill level == 0 / == DEPTH
//   o_almost_full     fill level >= ALMOST_FULL
//   o_overflow        sticky: a sample was dropped
//   i_clr_overflow    clears o_overflow (a same-edge overflow wins)
module fir_sample_fifo #(
    parameter int DATA_WIDTH  = 24,
    parameter int DEPTH       = 8,
    parameter int ALMOST_FULL = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [DATA_WIDTH-1:0]      iv_din,
    input  logic                       i_din_valid,
    output logic [DATA_WIDTH-1:0]      ov_dout,
    output logic                       o_dout_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     ov_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    input  logic                       i_clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]         remain, count_n;
    logic [DATA_WIDTH-1:0] dout_n;
    logic                  push, pop, push_ok;

    // The head lives in mem as well; ov_dout is a registered copy of the
    // entry that will be at rd_ptr after this edge. When the FIFO drains to
    // nothing but the incoming sample, that sample bypasses mem.
    always_comb begin
        push     = i_en & i_din_valid;
        pop      = i_en & i_ready & o_dout_valid;
        push_ok  = push & (~o_full | pop);
        remain   = ov_count - CW'(pop);
        count_n  = remain + CW'(push_ok);
        rd_ptr_n = rd_ptr + AW'(pop);
        dout_n   = (count_n == '0) ? ov_dout : (remain == '0) ? iv_din : mem[rd_ptr_n];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ov_count      <= '0;
            ov_dout       <= '0;
            o_dout_valid  <= 1'b0;
            o_empty       <= 1'b1;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= iv_din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr        <= rd_ptr_n;
            ov_count      <= count_n;
            ov_dout       <= dout_n;
            o_dout_valid  <= count_n != '0;
            o_empty       <= count_n == '0;
            o_full        <= count_n == CW'(DEPTH);
            o_almost_full <= count_n >= CW'(ALMOST_FULL);
            o_overflow    <= (push & o_full & ~pop) | (o_overflow & ~i_clr_overflow);
        end
    end
endmodule

// File: tb/tb_fir_sample_fifo.sv
// tb_fir_sample_fifo: directed self-checking bench for fir_sample_fifo (DEPTH=4, ALMOST_FULL=3)
module tb_fir_sample_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [23:0] din = '0;
    logic        din_valid = 1'b0;
    logic [23:0] dout;
    logic        dout_valid;
    logic        ready = 1'b0;
    logic [2:0]  count;
    logic        empty, full, almost_full, overflow;
    logic        clr = 1'b0;

    int checks = 0;
    int passed = 0;
    int got = 0;
    logic [23:0] sent [200];

    fir_sample_fifo #(.DATA_WIDTH(24), .DEPTH(4), .ALMOST_FULL(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
        .ov_dout(dout), .o_dout_valid(dout_valid), .i_ready(ready), .ov_count(count),
        .o_empty(empty), .o_full(full), .o_almost_full(almost_full),
        .o_overflow(overflow), .i_clr_overflow(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] v);
        din = v;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [23:0] v);
        chk(tag, {31'd0, dout_valid}, 32'd1);
        chk(tag, {8'd0, dout}, {8'd0, v});
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_dout", {8'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_flags", {28'd0, empty, full, almost_full, overflow}, 32'b1000);
        rst = 1'b0;
        tick();

        // single sample, latency 1, stable while idle
        push(24'h000011);
        chk("t1_valid", {31'd0, dout_valid}, 32'd1);
        chk("t1_dout", {8'd0, dout}, 32'h11);
        chk("t1_count", {29'd0, count}, 32'd1);
        chk("t1_empty", {31'd0, empty}, 32'd0);
        repeat (5) tick();
        chk("t1_hold_valid", {31'd0, dout_valid}, 32'd1);
        chk("t1_hold_dout", {8'd0, dout}, 32'h11);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t1_pop_valid", {31'd0, dout_valid}, 32'd0);
        chk("t1_pop_empty", {31'd0, empty}, 32'd1);
        chk("t1_pop_keep", {8'd0, dout}, 32'h11);

        // fill to full, spaced drain
        push(24'h1);
        push(24'h2);
        chk("t2_af2", {31'd0, almost_full}, 32'd0);
        push(24'h3);
        chk("t2_af3", {30'd0, almost_full, full}, 32'b10);
        push(24'h4);
        chk("t2_full", {30'd0, almost_full, full}, 32'b11);
        chk("t2_count", {29'd0, count}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            repeat (5) tick();
            pop_expect("t2_drain", 24'(i));
        end
        chk("t2_empty", {31'd0, empty}, 32'd1);

        // overflow and clear
        for (int i = 1; i <= 4; i++) push(24'h20 + 24'(i));
        push(24'hAA);
        chk("t3_ovf", {31'd0, overflow}, 32'd1);
        chk("t3_count", {29'd0, count}, 32'd4);
        chk("t3_head", {8'd0, dout}, 32'h21);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clr", {31'd0, overflow}, 32'd0);
        clr = 1'b1;
        push(24'hAA);
        clr = 1'b0;
        chk("t3_clr_vs_ovf", {31'd0, overflow}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clr2", {31'd0, overflow}, 32'd0);

        // enable low: strobes ignored, no overflow, outputs hold
        en = 1'b0;
        ready = 1'b1;
        push(24'hCC);
        ready = 1'b0;
        en = 1'b1;
        chk("en_count", {29'd0, count}, 32'd4);
        chk("en_ovf", {31'd0, overflow}, 32'd0);
        chk("en_head", {8'd0, dout}, 32'h21);

        // push + pop while full
        ready = 1'b1;
        push(24'hBB);
        ready = 1'b0;
        chk("t4_count", {29'd0, count}, 32'd4);
        chk("t4_ovf", {31'd0, overflow}, 32'd0);
        pop_expect("t4_d0", 24'h22);
        pop_expect("t4_d1", 24'h23);
        pop_expect("t4_d2", 24'h24);
        pop_expect("t4_d3", 24'hBB);
        chk("t4_empty", {31'd0, empty}, 32'd1);

        // push + pop at fill level 1
        push(24'h5);
        ready = 1'b1;
        push(24'h6);
        ready = 1'b0;
        chk("t5_valid", {31'd0, dout_valid}, 32'd1);
        chk("t5_dout", {8'd0, dout}, 32'h6);
        chk("t5_count", {29'd0, count}, 32'd1);
        pop_expect("t5_pop", 24'h6);

        // asynchronous reset between edges
        push(24'h31);
        push(24'h32);
        push(24'h33);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, dout_valid}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        #1 rst = 1'b0;
        tick();
        push(24'h7);
        chk("t6_count1", {29'd0, count}, 32'd1);
        pop_expect("t6_first", 24'h7);
        chk("t6_empty", {31'd0, empty}, 32'd1);

        // slow source, multi-cycle consumer
        for (int i = 0; i < 200; i++) sent[i] = 24'($urandom);
        fork
            for (int i = 0; i < 200; i++) begin
                push(sent[i]);
                repeat (39) tick();
            end
            begin
                int cyc = 0;
                while (got < 200 && cyc < 9000) begin
                    @(posedge clk);
                    #2;
                    cyc++;
                    if (dout_valid) begin
                        chk("stream_data", {8'd0, dout}, {8'd0, sent[got]});
                        repeat (5) tick();
                        ready = 1'b1;
                        tick();
                        ready = 1'b0;
                        got++;
                    end
                end
            end
        join
        chk("stream_count", got, 32'd200);
        chk("stream_ovf", {31'd0, overflow}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
